// File: rtl/bench_harness_pkg.sv
// bench_harness_pkg: run FSM state encoding and the width helper for the HOLD/DRAIN counter
package bench_harness_pkg;
  typedef enum logic [2:0] {IDLE, HOLD, RUN, DRAIN, DONE} state_e;
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/run_supervisor.sv
// run_supervisor: run FSM with core reset sequencing, cycle budget, sticky halt tracking; ports: i_clock/i_reset, i_start, i_halted in; o_core_reset/o_running/o_done/o_timed_out/o_cycles/o_halt_mask/o_prog_open out
module run_supervisor
  import bench_harness_pkg::*;
#(
  parameter int NUM_CORES    = 1,
  parameter int CNT_W        = 16,
  parameter int MAX_CYCLES   = 1990,
  parameter int RESET_CYCLES = 4,
  parameter int DRAIN_CYCLES = 8
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [NUM_CORES-1:0] i_halted,
  output logic                 o_core_reset,
  output logic                 o_running,
  output logic                 o_done,
  output logic                 o_timed_out,
  output logic [CNT_W-1:0]     o_cycles,
  output logic [NUM_CORES-1:0] o_halt_mask,
  output logic                 o_prog_open
);
  localparam int CW = cnt_w(RESET_CYCLES > DRAIN_CYCLES ? RESET_CYCLES : DRAIN_CYCLES);
  localparam logic [CW-1:0] HOLD_LAST = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES == 0 ? 0 : DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(MAX_CYCLES);
  state_e r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [CNT_W-1:0] r_cycles, w_cycles_inc;
  logic [NUM_CORES-1:0] r_halt_mask, w_seen;
  logic r_timed_out, w_all_halted, w_budget_out, w_open;
  assign w_seen = r_halt_mask | i_halted;
  assign w_all_halted = &w_seen;
  assign w_cycles_inc = r_cycles + 1'b1;
  assign w_budget_out = w_cycles_inc == CYC_LAST;
  assign w_open = r_state == IDLE || r_state == DONE;
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: if (i_start) w_next = HOLD;
      HOLD:       if (r_cnt == HOLD_LAST) w_next = RUN;
      RUN:        w_next = w_all_halted ? (DRAIN_CYCLES == 0 ? DONE : DRAIN) : (w_budget_out ? DONE : RUN);
      DRAIN:      if (r_cnt == DRAIN_LAST) w_next = DONE;
      default:    w_next = IDLE;
    endcase
  end
  always_comb begin
    o_running = r_state == RUN || r_state == DRAIN;
    o_core_reset = !o_running;
    o_done = r_state == DONE;
    o_prog_open = w_open;
  end
  // one counter serves both HOLD and DRAIN; it restarts from zero on every state change
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) begin
      r_cnt <= '0;
      r_cycles <= '0;
      r_halt_mask <= '0;
      r_timed_out <= 1'b0;
    end else begin
      r_cnt <= (w_next == r_state && (r_state == HOLD || r_state == DRAIN)) ? r_cnt + 1'b1 : '0;
      if (w_open && i_start) begin
        r_cycles <= '0;
        r_halt_mask <= '0;
        r_timed_out <= 1'b0;
      end else if (r_state == RUN) begin
        r_cycles <= w_cycles_inc;
        r_halt_mask <= w_seen;
        r_timed_out <= !w_all_halted && w_budget_out;
      end
    end
  assign o_cycles = r_cycles;
  assign o_halt_mask = r_halt_mask;
  assign o_timed_out = r_timed_out;
endmodule

// File: rtl/bench_harness.sv
// bench_harness: shared instruction memory with per-core async read ports plus run supervisor; ports: clock/reset, start, prog_* write, raddr->instr, halted in; core_reset/running/done/timed_out/cycles/halt_mask out
module bench_harness
  import bench_harness_pkg::*;
#(
  parameter int NUM_CORES    = 1,
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 32,
  parameter int CNT_W        = 16,
  parameter int MAX_CYCLES   = 1990,
  parameter int RESET_CYCLES = 4,
  parameter int DRAIN_CYCLES = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        prog_we,
  input  logic [ADDR_W-1:0]           prog_addr,
  input  logic [DATA_W-1:0]           prog_wdata,
  input  logic [NUM_CORES*ADDR_W-1:0] raddr,
  output logic [NUM_CORES*DATA_W-1:0] instr,
  input  logic [NUM_CORES-1:0]        halted,
  output logic                        core_reset,
  output logic                        running,
  output logic                        done,
  output logic                        timed_out,
  output logic [CNT_W-1:0]            cycles,
  output logic [NUM_CORES-1:0]        halt_mask
);
  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic w_prog_open;
  always_ff @(posedge clock)
    if (prog_we && w_prog_open) r_mem[prog_addr] <= prog_wdata;
  for (genvar i = 0; i < NUM_CORES; i++) begin : g_rd
    assign instr[i*DATA_W +: DATA_W] = r_mem[raddr[i*ADDR_W +: ADDR_W]];
  end
  run_supervisor #(
    .NUM_CORES(NUM_CORES), .CNT_W(CNT_W), .MAX_CYCLES(MAX_CYCLES),
    .RESET_CYCLES(RESET_CYCLES), .DRAIN_CYCLES(DRAIN_CYCLES)
  ) u_sup (
    .i_clock(clock), .i_reset(reset), .i_start(start), .i_halted(halted),
    .o_core_reset(core_reset), .o_running(running), .o_done(done),
    .o_timed_out(timed_out), .o_cycles(cycles), .o_halt_mask(halt_mask),
    .o_prog_open(w_prog_open)
  );
endmodule

// File: tb/tb_bench_harness.sv
// tb_bench_harness: randomized directed bench for bench_harness against a run-outcome model
module tb_bench_harness;
  localparam int NC = 4, AW = 8, DW = 32, CW = 16, MAXC = 1990, RC = 4, DC = 8, B_MAX = 60;
  logic clock = 0, reset = 1, start = 0, prog_we = 0;
  logic [AW-1:0] prog_addr = '0;
  logic [DW-1:0] prog_wdata = '0;
  logic [NC*AW-1:0] raddr = '0;
  logic [NC*DW-1:0] instr;
  logic [NC-1:0] halted = '0, halt_mask;
  logic core_reset, running, done, timed_out;
  logic [CW-1:0] cycles;
  logic b_start = 0;
  logic [AW-1:0] b_raddr = '0;
  logic [DW-1:0] b_instr;
  logic [0:0] b_halted = '0, b_halt_mask;
  logic b_core_reset, b_running, b_done, b_timed_out;
  logic [CW-1:0] b_cycles;
  logic [DW-1:0] mem_m [13];
  int n_chk = 0, n_pass = 0;
  int hv[NC];
  logic [DW-1:0] wd;

  always #5 clock = ~clock;

  bench_harness #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .CNT_W(CW),
    .MAX_CYCLES(MAXC), .RESET_CYCLES(RC), .DRAIN_CYCLES(DC)) u_a (
    .clock(clock), .reset(reset), .start(start), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_wdata(prog_wdata), .raddr(raddr), .instr(instr),
    .halted(halted), .core_reset(core_reset), .running(running), .done(done),
    .timed_out(timed_out), .cycles(cycles), .halt_mask(halt_mask));

  bench_harness #(.NUM_CORES(1), .ADDR_W(AW), .DATA_W(DW), .CNT_W(CW),
    .MAX_CYCLES(B_MAX), .RESET_CYCLES(1), .DRAIN_CYCLES(0)) u_b (
    .clock(clock), .reset(reset), .start(b_start), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_wdata(prog_wdata), .raddr(b_raddr), .instr(b_instr),
    .halted(b_halted), .core_reset(b_core_reset), .running(b_running), .done(b_done),
    .timed_out(b_timed_out), .cycles(b_cycles), .halt_mask(b_halt_mask));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    prog_we = 1; prog_addr = AW'(a); prog_wdata = d;
    tick();
    prog_we = 0;
    mem_m[a] = d;
  endtask

  task automatic chk_mem(input string tag);
    int a[NC];
    for (int i = 0; i < NC; i++) begin
      a[i] = $urandom_range(0, 12);
      raddr[i*AW +: AW] = AW'(a[i]);
    end
    #1;
    for (int i = 0; i < NC; i++) chk(tag, instr[i*DW +: DW], mem_m[a[i]]);
  endtask

  // h[i] = run cycle at which core i first raises halted (0 = never)
  task automatic run_a(input int h[NC], input bit pulse, input bit disturb, input string tag);
    int last;
    bit never, exp_to;
    int endk;
    logic [NC-1:0] m;
    never = 0; last = 0; m = '0;
    foreach (h[i]) if (h[i] == 0) never = 1; else if (h[i] > last) last = h[i];
    exp_to = never || last > MAXC;
    endk = exp_to ? MAXC : last;
    start = 1;
    tick();
    start = 0;
    chk({tag, ":entry"}, {core_reset, running, done, timed_out, halt_mask, cycles},
        {1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0});
    for (int j = 1; j <= RC; j++) begin
      tick();
      chk({tag, ":hold"}, core_reset, j < RC);
    end
    for (int k = 1; k <= endk; k++) begin
      for (int i = 0; i < NC; i++) halted[i] = h[i] != 0 && (pulse ? k == h[i] : k >= h[i]);
      if (disturb) begin
        prog_we = 1'($urandom); prog_addr = AW'($urandom_range(0, 12));
        prog_wdata = $urandom; start = 1'($urandom);
      end
      tick();
      for (int i = 0; i < NC; i++) m[i] = h[i] != 0 && h[i] <= k;
      chk({tag, ":cyc"}, {cycles, halt_mask}, {CW'(k), m});
      chk({tag, ":state"}, {running, done, timed_out, core_reset},
          k < endk ? 4'b1000 : (exp_to ? 4'b0111 : 4'b1000));
    end
    if (!exp_to)
      for (int d = 1; d <= DC; d++) begin
        if (disturb) begin
          prog_we = 1'($urandom); prog_addr = AW'($urandom_range(0, 12));
          prog_wdata = $urandom; start = 1'($urandom);
        end
        tick();
        chk({tag, ":drain"}, {running, done, timed_out, core_reset, cycles, halt_mask},
            {d < DC ? 4'b1000 : 4'b0101, CW'(endk), {NC{1'b1}}});
      end
    prog_we = 0; start = 0; halted = '0;
    tick();
    tick();
    chk({tag, ":held"}, {done, timed_out, cycles, halt_mask}, {1'b1, exp_to, CW'(endk), m});
  endtask

  task automatic run_b(input int h, input string tag);
    bit exp_to;
    int endk;
    exp_to = h == 0 || h > B_MAX;
    endk = exp_to ? B_MAX : h;
    b_start = 1;
    tick();
    b_start = 0;
    chk({tag, ":entry"}, {b_core_reset, b_running, b_done, b_cycles}, {3'b100, 16'h0});
    tick();
    chk({tag, ":rel"}, {b_core_reset, b_running}, 2'b01);
    for (int k = 1; k <= endk; k++) begin
      b_halted[0] = h != 0 && k >= h;
      tick();
      chk({tag, ":cyc"}, b_cycles, CW'(k));
      chk({tag, ":state"}, {b_running, b_done, b_timed_out, b_core_reset},
          k < endk ? 4'b1000 : (exp_to ? 4'b0111 : 4'b0101));
    end
    b_halted = '0;
    tick();
    chk({tag, ":held"}, {b_done, b_timed_out, b_cycles, b_halt_mask}, {1'b1, exp_to, CW'(endk), !exp_to});
  endtask

  initial begin
    #2;
    chk("rst_a", {core_reset, running, done, timed_out, cycles, halt_mask}, {4'b1000, 16'h0, 4'h0});
    chk("rst_b", {b_core_reset, b_running, b_done, b_timed_out, b_cycles, b_halt_mask}, {4'b1000, 16'h0, 1'b0});
    @(negedge clock);
    reset = 0;
    tick();
    for (int a = 0; a < 13; a++) wr(a, $urandom);
    repeat (3) chk_mem("mem_load");
    b_raddr = 8'd3;
    #1;
    chk("b_instr", b_instr, mem_m[3]);
    raddr[AW-1:0] = 8'd5;
    wd = ~mem_m[5];
    prog_we = 1; prog_addr = 8'd5; prog_wdata = wd;
    #1;
    chk("wr_old", instr[DW-1:0], mem_m[5]);
    tick();
    prog_we = 0;
    mem_m[5] = wd;
    chk("wr_new", instr[DW-1:0], mem_m[5]);
    hv = '{100, 1, 1, 1};
    run_a(hv, 0, 0, "halt100");
    chk_mem("mem_run1");
    hv = '{0, 0, 0, 0};
    run_a(hv, 0, 0, "timeout");
    hv = '{10, 40, 25, 70};
    run_a(hv, 0, 0, "four");
    hv = '{MAXC, 3, 3, 3};
    run_a(hv, 1, 0, "coincide");
    for (int i = 0; i < NC; i++) hv[i] = $urandom_range(1, 200);
    run_a(hv, 1'($urandom), 1, "disturb");
    repeat (3) chk_mem("mem_keep");
    wr(7, $urandom);
    chk_mem("wr_done");
    run_b(5, "b_halt");
    run_b(0, "b_to");
    run_b(B_MAX, "b_edge");
    start = 1;
    tick();
    start = 0;
    repeat (RC) tick();
    for (int k = 1; k <= 50; k++) begin
      halted = k >= 40 ? 4'b0011 : 4'b0000;
      tick();
    end
    chk("pre_rst", {cycles, halt_mask, running}, {16'd50, 4'b0011, 1'b1});
    reset = 1;
    #1;
    chk("mid_rst", {core_reset, running, done, timed_out, cycles, halt_mask}, {4'b1000, 16'h0, 4'h0});
    halted = '0;
    #1;
    reset = 0;
    tick();
    chk("idle_after", {core_reset, running, done}, 3'b100);
    repeat (3) chk_mem("mem_ret");
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NC; i++) hv[i] = $urandom_range(1, 150);
      run_a(hv, 1'($urandom), 1'($urandom), "rerun");
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
